psoc_audio_dma: RTL and testbench

// - Wishbone read master that streams stereo samples from a ring buffer in system memory into the audio sample FIFO.
// - Sits beside the audio IP and drives the FIFO write side (48-bit data + write strobe) in place of CPU register writes.
// - Refills in bursts whenever the FIFO reports low, so the I2S/DAC consumer never starves without CPU involvement.

---
 rtl/psoc_audio_dma_pkg.sv | 16 +
 rtl/psoc_audio_dma_if.sv | 43 ++++
 rtl/psoc_audio_dma_addr.sv | 24 ++
 rtl/psoc_audio_dma.sv | 121 ++++++++++++
 tb/tb_psoc_audio_dma.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/psoc_audio_dma_pkg.sv
// Shared types and constants for the audio ring-buffer DMA.
package psoc_audio_dma_pkg;

    localparam int unsigned SAMPLE_W    = 24;
    localparam int unsigned FIFO_DATA_W = 2 * SAMPLE_W;
    localparam int unsigned ADDR_W      = 32;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StRdL,
        StRdR,
        StPush
    } state_e;

endpackage

// File: rtl/psoc_audio_dma_if.sv
// Control, FIFO write side and Wishbone master signals of the audio DMA.
interface psoc_audio_dma_if #(
    parameter int unsigned FIFO_LEN_BITS = 8,
    parameter int unsigned IDX_W         = 16
);
    import psoc_audio_dma_pkg::*;

    logic                     enable;
    logic [ADDR_W-1:0]        base_addr;
    logic [IDX_W-1:0]         ring_len;
    logic                     fifo_low;
    logic                     fifo_full;
    logic [FIFO_LEN_BITS:0]   fifo_level;
    logic [FIFO_DATA_W-1:0]   fifo_data_o;
    logic                     fifo_write_o;
    logic [ADDR_W-1:0]        wbm_adr_o;
    logic [31:0]              wbm_dat_i;
    logic                     wbm_cyc_o;
    logic                     wbm_stb_o;
    logic                     wbm_we_o;
    logic [3:0]               wbm_sel_o;
    logic                     wbm_ack_i;
    logic                     wbm_err_i;
    logic                     busy;
    logic                     bus_err;
    logic                     wrap_pulse;
    logic [IDX_W-1:0]         cur_idx;

    modport master (
        input  enable, base_addr, ring_len, fifo_low, fifo_full, fifo_level,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i,
        output fifo_data_o, fifo_write_o, wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
        output busy, bus_err, wrap_pulse, cur_idx
    );

    modport slave (
        output enable, base_addr, ring_len, fifo_low, fifo_full, fifo_level,
        output wbm_dat_i, wbm_ack_i, wbm_err_i,
        input  fifo_data_o, fifo_write_o, wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
        input  busy, bus_err, wrap_pulse, cur_idx
    );

endinterface

// File: rtl/psoc_audio_dma_addr.sv
// Ring index wrap and sample word address generation.
module psoc_audio_dma_addr
    import psoc_audio_dma_pkg::*;
#(
    parameter int unsigned IDX_W = 16
) (
    input  logic [ADDR_W-1:0] i_base,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [IDX_W-1:0]  i_len,
    input  logic              i_right,
    output logic [ADDR_W-1:0] o_adr,
    output logic [IDX_W-1:0]  o_idx_nxt,
    output logic              o_wrap
);

    // idx*8 + 4*right, kept IDX_W+3 bits wide and zero-extended
    logic [IDX_W+2:0] w_off;

    assign w_off     = {i_idx, i_right, 2'b00};
    assign o_adr     = i_base + ADDR_W'(w_off);
    assign o_wrap    = (i_idx == i_len - IDX_W'(1));
    assign o_idx_nxt = o_wrap ? '0 : i_idx + IDX_W'(1);

endmodule

// File: rtl/psoc_audio_dma.sv
// Wishbone read master that refills the audio sample FIFO from a stereo ring buffer in memory.
module psoc_audio_dma
    import psoc_audio_dma_pkg::*;
#(
    parameter int unsigned FIFO_LEN_BITS = 8,
    parameter int unsigned BURST_MAX     = 16,
    parameter int unsigned IDX_W         = 16
) (
    input  logic             clk,
    input  logic             rstn,
    psoc_audio_dma_if.master bus
);

    localparam int unsigned CNT_W  = FIFO_LEN_BITS + 1;
    localparam int unsigned FREE_W = FIFO_LEN_BITS + 2;

    state_e              r_state, w_state_nxt;
    logic                r_enable_q, r_bus_err;
    logic [ADDR_W-1:0]   r_base, w_adr;
    logic [IDX_W-1:0]    r_len, r_idx, w_idx_nxt;
    logic [CNT_W-1:0]    r_burst, w_burst_init;
    logic [FREE_W-1:0]   w_free;
    logic [SAMPLE_W-1:0] r_left, r_right;
    logic                w_wrap, w_rd, w_more, w_rise, w_unused;

    assign w_rise       = bus.enable & ~r_enable_q;
    assign w_rd         = (r_state == StRdL) || (r_state == StRdR);
    assign w_more       = (r_burst > CNT_W'(1)) && bus.enable;
    assign w_free       = FREE_W'(2 ** FIFO_LEN_BITS) - FREE_W'(bus.fifo_level);
    assign w_burst_init = (w_free > FREE_W'(BURST_MAX)) ? CNT_W'(BURST_MAX) : CNT_W'(w_free);
    assign w_unused     = ^{bus.wbm_dat_i[31:SAMPLE_W], bus.base_addr[2:0]};

    psoc_audio_dma_addr #(
        .IDX_W (IDX_W)
    ) u_addr (
        .i_base    (r_base),
        .i_idx     (r_idx),
        .i_len     (r_len),
        .i_right   (r_state == StRdR),
        .o_adr     (w_adr),
        .o_idx_nxt (w_idx_nxt),
        .o_wrap    (w_wrap)
    );

    // r_enable_q gates the start so a freshly latched config is used
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (bus.enable && r_enable_q && !r_bus_err && (r_len != '0) &&
                    bus.fifo_low && !bus.fifo_full) begin
                    w_state_nxt = StStart;
                end
            end
            StStart: w_state_nxt = (w_burst_init == '0) ? StIdle : StRdL;
            StRdL: begin
                if (bus.wbm_err_i)      w_state_nxt = StIdle;
                else if (bus.wbm_ack_i) w_state_nxt = StRdR;
            end
            StRdR: begin
                if (bus.wbm_err_i)      w_state_nxt = StIdle;
                else if (bus.wbm_ack_i) w_state_nxt = StPush;
            end
            StPush:  w_state_nxt = w_more ? StRdL : StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= StIdle;
            r_enable_q <= 1'b0;
            r_bus_err  <= 1'b0;
            r_base     <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_burst    <= '0;
            r_left     <= '0;
            r_right    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_enable_q <= bus.enable;
            if (w_rise && (r_state == StIdle)) begin
                r_base <= {bus.base_addr[ADDR_W-1:3], 3'b000};
                r_len  <= bus.ring_len;
                r_idx  <= '0;
            end
            if (w_rd && bus.wbm_err_i) begin
                r_bus_err <= 1'b1;
            end else if (!bus.enable) begin
                r_bus_err <= 1'b0;
            end
            if (r_state == StStart) begin
                r_burst <= w_burst_init;
            end
            if ((r_state == StRdL) && bus.wbm_ack_i && !bus.wbm_err_i) begin
                r_left <= bus.wbm_dat_i[SAMPLE_W-1:0];
            end
            if ((r_state == StRdR) && bus.wbm_ack_i && !bus.wbm_err_i) begin
                r_right <= bus.wbm_dat_i[SAMPLE_W-1:0];
            end
            if (r_state == StPush) begin
                r_idx   <= w_idx_nxt;
                r_burst <= r_burst - CNT_W'(1);
            end
        end
    end

    assign bus.wbm_cyc_o    = w_rd || ((r_state == StPush) && w_more);
    assign bus.wbm_stb_o    = w_rd;
    assign bus.wbm_adr_o    = w_rd ? w_adr : '0;
    assign bus.wbm_we_o     = 1'b0;
    assign bus.wbm_sel_o    = 4'hF;
    assign bus.fifo_write_o = (r_state == StPush);
    assign bus.fifo_data_o  = (r_state == StPush) ? {r_right, r_left} : '0;
    assign bus.wrap_pulse   = (r_state == StPush) && w_wrap;
    assign bus.busy         = (r_state != StIdle);
    assign bus.bus_err      = r_bus_err;
    assign bus.cur_idx      = r_idx;

endmodule

// File: tb/tb_psoc_audio_dma.sv
// Self-checking bench for psoc_audio_dma: memory-backed Wishbone slave plus ring-buffer model.
module tb_psoc_audio_dma;

    localparam int unsigned FLB  = 8;
    localparam int unsigned BMAX = 16;
    localparam int unsigned IW   = 16;

    typedef struct {
        logic [IW-1:0] len;
        logic [31:0]   base;
        int            level;
        int            exp_wr;
        int            exp_wrap;
    } vec_t;

    logic clk;
    logic rstn;

    psoc_audio_dma_if #(.FIFO_LEN_BITS(FLB), .IDX_W(IW)) bus ();

    psoc_audio_dma #(
        .FIFO_LEN_BITS (FLB),
        .BURST_MAX     (BMAX),
        .IDX_W         (IW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model of the ring: next sample index, latched length and base
    int unsigned m_idx = 0;
    int unsigned m_len = 0;
    logic [31:0] m_base = '0;
    logic [31:0] mem_seed = '0;

    int wr_cnt = 0, wrap_cnt = 0, cyc_cnt = 0;
    int word_no = 0, err_word = 0, hold_after = 0, max_wait = 0;
    bit phase = 0, hold_ack = 0, err_pending = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ mem_seed ^ {a[15:0], a[31:16]};
    endfunction

    function automatic logic [31:0] word_addr(input int unsigned idx, input bit right);
        logic [31:0] b;
        b = {m_base[31:3], 3'b000};
        return b + (idx * 8) + (right ? 32'd4 : 32'd0);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Memory-backed Wishbone slave with random wait states and fault injection
    initial begin
        int wait_left;
        logic [31:0] exp_adr;
        wait_left = 0;
        bus.wbm_ack_i = 1'b0;
        bus.wbm_err_i = 1'b0;
        bus.wbm_dat_i = '0;
        forever begin
            @(negedge clk);
            bus.wbm_ack_i = 1'b0;
            bus.wbm_err_i = 1'b0;
            if (err_pending) begin
                check("err_cyc_drop", 64'({bus.wbm_cyc_o, bus.wbm_stb_o}), 64'd0);
                err_pending = 0;
            end
            if (rstn && bus.wbm_stb_o && !hold_ack) begin
                if (wait_left > 0) begin
                    wait_left--;
                end else begin
                    word_no++;
                    if (word_no == err_word) begin
                        bus.wbm_err_i = 1'b1;
                        err_pending = 1;
                        phase = 0;
                    end else begin
                        exp_adr = word_addr(m_idx, phase);
                        check("bus_adr",
                              64'({bus.wbm_cyc_o, bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_adr_o}),
                              64'({1'b1, 1'b0, 4'hF, exp_adr}));
                        bus.wbm_dat_i = mem_word(bus.wbm_adr_o);
                        bus.wbm_ack_i = 1'b1;
                        phase = !phase;
                        if (word_no == hold_after) hold_ack = 1;
                    end
                    wait_left = (max_wait > 0) ? int'($urandom_range(0, max_wait)) : 0;
                end
            end
        end
    end

    // FIFO-side scoreboard: every push must be the next ring sample
    initial begin
        logic [31:0] lw, rw;
        forever begin
            @(negedge clk);
            if (bus.wbm_cyc_o) cyc_cnt++;
            if (bus.wrap_pulse) wrap_cnt++;
            if (bus.fifo_write_o) begin
                lw = mem_word(word_addr(m_idx, 0));
                rw = mem_word(word_addr(m_idx, 1));
                check("push_data", 64'(bus.fifo_data_o), 64'({rw[23:0], lw[23:0]}));
                check("push_wrap", 64'(bus.wrap_pulse), 64'(m_idx == m_len - 1));
                m_idx = (m_idx == m_len - 1) ? 0 : m_idx + 1;
                wr_cnt++;
            end
        end
    end

    task automatic relatch(input int unsigned len, input logic [31:0] base);
        bus.enable = 1'b0;
        bus.ring_len = IW'(len);
        bus.base_addr = base;
        tick(2);
        bus.enable = 1'b1;
        m_len = len;
        m_base = base;
        m_idx = 0;
        phase = 0;
        tick(2);
    endtask

    task automatic run_burst(input int level, input int exp_wr, input int exp_wrap,
                             input string tag);
        int t;
        wr_cnt = 0;
        wrap_cnt = 0;
        bus.fifo_level = (FLB + 1)'(level);
        bus.fifo_low = 1'b1;
        t = 0;
        while (!bus.busy && t < 20) begin tick(1); t++; end
        check({tag, "_start"}, 64'(bus.busy), 64'd1);
        bus.fifo_low = 1'b0;
        t = 0;
        while (bus.busy && t < 3000) begin tick(1); t++; end
        check({tag, "_done"}, 64'(bus.busy), 64'd0);
        tick(2);
        check({tag, "_writes"}, 64'(wr_cnt), 64'(exp_wr));
        check({tag, "_wraps"}, 64'(wrap_cnt), 64'(exp_wrap));
    endtask

    initial begin
        vec_t vecs[6];
        int t, n, wraps;
        int unsigned rlen, start;

        vecs[0] = '{len: 16'd4,  base: 32'h0000_1000, level: 250, exp_wr: 6,  exp_wrap: 1};
        vecs[1] = '{len: 16'd40, base: 32'h0000_2000, level: 0,   exp_wr: 16, exp_wrap: 0};
        vecs[2] = '{len: 16'd1,  base: 32'h0000_0040, level: 252, exp_wr: 4,  exp_wrap: 4};
        vecs[3] = '{len: 16'd3,  base: 32'hFFFF_FFF0, level: 251, exp_wr: 5,  exp_wrap: 1};
        vecs[4] = '{len: 16'd5,  base: 32'h0000_3007, level: 255, exp_wr: 1,  exp_wrap: 0};
        vecs[5] = '{len: 16'd5,  base: 32'h0000_0500, level: 256, exp_wr: 0,  exp_wrap: 0};

        mem_seed = $urandom;
        rstn = 1'b0;
        bus.enable = 1'b0;
        bus.base_addr = '0;
        bus.ring_len = '0;
        bus.fifo_low = 1'b0;
        bus.fifo_full = 1'b0;
        bus.fifo_level = '0;
        tick(3);

        check("rst_bus", 64'({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o}),
              64'({1'b0, 1'b0, 1'b0, 4'hF}));
        check("rst_adr", 64'(bus.wbm_adr_o), 64'd0);
        check("rst_fifo", 64'({bus.fifo_write_o, bus.fifo_data_o}), 64'd0);
        check("rst_status", 64'({bus.busy, bus.bus_err, bus.wrap_pulse, bus.cur_idx}), 64'd0);
        rstn = 1'b1;
        tick(2);

        for (int i = 0; i < 6; i++) begin
            relatch(vecs[i].len, vecs[i].base);
            max_wait = int'($urandom_range(0, 2));
            run_burst(vecs[i].level, vecs[i].exp_wr, vecs[i].exp_wrap, $sformatf("vec%0d", i));
        end

        // Random bursts over one ring; the index carries across bursts
        rlen = $urandom_range(1, 7);
        relatch(rlen, $urandom);
        for (int i = 0; i < 4; i++) begin
            t = int'($urandom_range(0, 256));
            n = (256 - t < int'(BMAX)) ? 256 - t : int'(BMAX);
            start = m_idx;
            wraps = 0;
            for (int j = 1; j <= n; j++) if ((start + j) % rlen == 0) wraps++;
            max_wait = int'($urandom_range(0, 3));
            run_burst(t, n, wraps, $sformatf("rnd%0d", i));
            check("rnd_idx", 64'(bus.cur_idx), 64'(m_idx));
        end

        // Bus error on the third word
        relatch(8, 32'h0000_4000);
        word_no = 0;
        err_word = 3;
        max_wait = 1;
        wr_cnt = 0;
        bus.fifo_level = '0;
        bus.fifo_low = 1'b1;
        t = 0;
        while (!bus.bus_err && t < 200) begin tick(1); t++; end
        check("err_flag", 64'(bus.bus_err), 64'd1);
        cyc_cnt = 0;
        tick(50);
        check("err_no_restart", 64'(cyc_cnt), 64'd0);
        check("err_writes", 64'(wr_cnt), 64'd1);
        check("err_state", 64'({bus.busy, bus.cur_idx}), 64'({1'b0, 16'd1}));
        bus.fifo_low = 1'b0;
        bus.enable = 1'b0;
        tick(2);
        check("err_clear", 64'(bus.bus_err), 64'd0);
        err_word = 0;
        relatch(8, 32'h0000_4000);
        run_burst(0, 16, 2, "err_rerun");

        // Enable dropped during the second sample of an eight-sample burst
        relatch(8, 32'h0000_5000);
        max_wait = 0;
        wr_cnt = 0;
        bus.fifo_level = 9'd248;
        bus.fifo_low = 1'b1;
        t = 0;
        while (wr_cnt < 1 && t < 50) begin tick(1); t++; end
        bus.fifo_low = 1'b0;
        tick(1);
        bus.enable = 1'b0;
        t = 0;
        while (bus.busy && t < 50) begin tick(1); t++; end
        tick(2);
        check("endrop_writes", 64'(wr_cnt), 64'd2);
        check("endrop_idx", 64'({bus.busy, bus.cur_idx}), 64'({1'b0, 16'd2}));

        // Asynchronous reset while waiting on the right word of sample 2
        relatch(8, 32'h0000_6000);
        word_no = 0;
        hold_after = 5;
        bus.fifo_level = '0;
        bus.fifo_low = 1'b1;
        t = 0;
        while (!hold_ack && t < 100) begin tick(1); t++; end
        tick(2);
        check("rst_pre_adr", 64'({bus.wbm_stb_o, bus.wbm_adr_o}), 64'({1'b1, 32'h0000_6014}));
        #3;
        rstn = 1'b0;
        bus.enable = 1'b0;
        bus.fifo_low = 1'b0;
        #1;
        check("rst_async",
              64'({bus.wbm_cyc_o, bus.wbm_stb_o, bus.fifo_write_o, bus.busy}), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        hold_ack = 0;
        hold_after = 0;
        m_idx = 0;
        phase = 0;
        tick(2);
        check("rst_idx", 64'({bus.busy, bus.cur_idx}), 64'd0);

        // No bus activity for an empty ring or a full FIFO
        relatch(0, 32'h0000_7000);
        bus.fifo_level = '0;
        bus.fifo_low = 1'b1;
        cyc_cnt = 0;
        tick(100);
        check("len0_quiet", 64'({bus.busy, 32'(cyc_cnt)}), 64'd0);
        bus.fifo_low = 1'b0;
        relatch(4, 32'h0000_7000);
        bus.fifo_full = 1'b1;
        bus.fifo_low = 1'b1;
        cyc_cnt = 0;
        tick(100);
        check("full_quiet", 64'({bus.busy, 32'(cyc_cnt)}), 64'd0);
        bus.fifo_low = 1'b0;
        bus.fifo_full = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
